// File: rtl/rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rom_loader: assembles big-endian 16-bit words from a framed byte stream    |
// | into the instruction ROM write port and holds the CPU in reset meanwhile.  |
// | Optional: define ROM_LOADER_CHECKSUM_EN to expect/verify a checksum byte.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rom_loader #(
  parameter int         ADDR_WIDTH     = 15,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [15:0]           dina,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] MAX_WORDS    = 17'd1 << ADDR_WIDTH;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_DONE
  } state_t;
`endif

  state_t                state_q;
  logic [7:0]            cnt_hi_q;
  logic [7:0]            data_hi_q;
  logic [15:0]           words_q;
  logic [31:0]           timer_q;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [15:0]           dina_q;
  logic                  wea_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  error_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q;
`endif

  logic [16:0] count_d;
  logic        sync_d;
  logic        timeout_d;

  assign count_d   = {1'b0, cnt_hi_q, rx_data};
  assign sync_d    = rx_valid && (rx_data == SYNC_BYTE);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_d = (state_q != S_IDLE) && (state_q != S_DONE) && !rx_valid &&
                     (timer_q == TIMEOUT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_hi_q   <= 8'h00;
      data_hi_q  <= 8'h00;
      words_q    <= 16'h0000;
      timer_q    <= 32'h0;
      addra_q    <= '0;
      dina_q     <= 16'h0000;
      wea_q      <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      wea_q  <= 1'b0;
      done_q <= 1'b0;
      if (wea_q) addra_q <= addra_q + ADDR_WIDTH'(1);

      if (state_q == S_IDLE || rx_valid) timer_q <= 32'h0;
      else                                timer_q <= timer_q + 32'd1;

      if (timeout_d) begin
        error_q <= 1'b1;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sync_d) begin
              state_q    <= S_CNT_HI;
              error_q    <= 1'b0;
              cpu_hold_q <= 1'b1;
              addra_q    <= '0;
            end
          end
          S_CNT_HI: begin
            if (rx_valid) begin
              cnt_hi_q <= rx_data;
`ifdef ROM_LOADER_CHECKSUM_EN
              sum_q    <= rx_data;
`endif
              state_q  <= S_CNT_LO;
            end
          end
          S_CNT_LO: begin
            if (rx_valid) begin
              words_q <= count_d[15:0];
`ifdef ROM_LOADER_CHECKSUM_EN
              sum_q   <= sum_q + rx_data;
`endif
              if (count_d > MAX_WORDS) begin
                error_q <= 1'b1;
                state_q <= S_IDLE;
              end else if (count_d == 17'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                state_q <= S_CHECK;
`else
                state_q <= S_DONE;
`endif
              end else begin
                state_q <= S_DATA_HI;
              end
            end
          end
          S_DATA_HI: begin
            if (rx_valid) begin
              data_hi_q <= rx_data;
`ifdef ROM_LOADER_CHECKSUM_EN
              sum_q     <= sum_q + rx_data;
`endif
              state_q   <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            if (rx_valid) begin
              wea_q   <= 1'b1;
              dina_q  <= {data_hi_q, rx_data};
              words_q <= words_q - 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
              sum_q   <= sum_q + rx_data;
`endif
              if (words_q != 16'd1) begin
                state_q <= S_DATA_HI;
              end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
                state_q <= S_CHECK;
`else
                state_q <= S_DONE;
`endif
              end
            end
          end
`ifdef ROM_LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (rx_valid) begin
              state_q <= S_IDLE;
              if (rx_data == sum_q) begin
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else begin
                error_q    <= 1'b1;
              end
            end
          end
`endif
          S_DONE: begin
            // Behaves as IDLE for the incoming byte so a strobe here is not lost.
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            state_q    <= S_IDLE;
            if (sync_d) begin
              state_q    <= S_CNT_HI;
              error_q    <= 1'b0;
              cpu_hold_q <= 1'b1;
              addra_q    <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rom_loader: directed self-checking bench for rom_loader.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rom_loader;

  localparam int AW = 15;
  localparam int TO = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wea;
  logic [AW-1:0] addra;
  logic [15:0]   dina;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int waddr[$];
  logic [15:0] wdata[$];
  int base;

  rom_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wea(wea), .addra(addra), .dina(dina), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wea === 1'b1) begin
      waddr.push_back(int'(addra));
      wdata.push_back(dina);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    idle(2);
    reset = 1'b1;
    idle(1);
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    check("rst_dina", dina, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);

`ifdef ROM_LOADER_CHECKSUM_EN
    put(8'hA5);
    check("s1_hold_rise", cpu_hold, 1);
    put(8'h00); put(8'h02); put(8'h12); put(8'h34);
    check("s1_w0_wea", wea, 1);
    check("s1_w0_addr", addra, 0);
    check("s1_w0_data", dina, 16'h1234);
    put(8'hAB); put(8'hCD);
    check("s1_w1_wea", wea, 1);
    check("s1_w1_addr", addra, 1);
    check("s1_w1_data", dina, 16'hABCD);
    put(8'hC0);
    check("s1_done", done, 1);
    check("s1_hold_fall", cpu_hold, 0);
    check("s1_error", error, 0);
    idle(1);
    check("s1_done_pulse", done, 0);

    base = waddr.size();
    put(8'hA5); put(8'h00); put(8'h02); put(8'h12); put(8'h34);
    put(8'hAB); put(8'hCD); put(8'hC1);
    check("s2_error", error, 1);
    check("s2_hold", cpu_hold, 1);
    check("s2_no_done", done, 0);
    idle(2);
    check("s2_writes", waddr.size(), base + 2);
    check("s2_w1_data", wdata[base+1], 16'hABCD);
    put(8'hA5);
    check("s2_err_clear", error, 0);
    put(8'h00); put(8'h02); put(8'h12); put(8'h34);
    put(8'hAB); put(8'hCD); put(8'hC0);
    check("s2_done", done, 1);
    check("s2_hold_fall", cpu_hold, 0);

    base = waddr.size();
    put(8'h00); put(8'hFF); put(8'h7E);
    idle(1);
    check("s3_ignored_hold", cpu_hold, 0);
    put(8'hA5); put(8'h00); put(8'h00); put(8'h00);
    check("s3_done", done, 1);
    check("s3_hold", cpu_hold, 0);
    idle(2);
    check("s3_no_write", waddr.size(), base);
    check("s3_done_cnt", done_cnt, 3);
`else
    put(8'hA5);
    check("s6_hold_rise", cpu_hold, 1);
    put(8'h00); put(8'h01); put(8'hBE); put(8'hEF);
    check("s6_wea", wea, 1);
    check("s6_addr", addra, 0);
    check("s6_data", dina, 16'hBEEF);
    idle(1);
    check("s6_wea_pulse", wea, 0);
    check("s6_done", done, 1);
    check("s6_hold_fall", cpu_hold, 0);
    check("s6_addr_adv", addra, 1);
    put(8'h12);
    idle(2);
    check("s6_idle_hold", cpu_hold, 0);
    check("s6_writes", waddr.size(), 1);
    check("s6_wdata", wdata[0], 16'hBEEF);

    base = waddr.size();
    put(8'hA5); put(8'h00); put(8'h03); put(8'h11); put(8'h22);
    put(8'h33); put(8'h44); put(8'h55); put(8'h66);
    check("mw_wea", wea, 1);
    check("mw_addr", addra, 2);
    check("mw_data", dina, 16'h5566);
    idle(1);
    check("mw_done", done, 1);
    idle(2);
    check("mw_writes", waddr.size(), base + 3);
    check("mw_w0_data", wdata[base], 16'h1122);
    check("mw_w1_addr", waddr[base+1], 1);
    check("mw_w1_data", wdata[base+1], 16'h3344);

    base = waddr.size();
    put(8'h00); put(8'hFF); put(8'h7E);
    idle(1);
    check("s3_ignored_hold", cpu_hold, 0);
    put(8'hA5); put(8'h00); put(8'h00);
    idle(1);
    check("s3_done", done, 1);
    check("s3_hold", cpu_hold, 0);
    put(8'h00);
    idle(2);
    check("s3_no_write", waddr.size(), base);
    check("s3_done_cnt", done_cnt, 3);
`endif

    base = waddr.size();
    put(8'hA5); put(8'h00); put(8'h01); put(8'h12);
    idle(TO - 1);
    check("to_before", error, 0);
    idle(1);
    check("to_error", error, 1);
    check("to_hold", cpu_hold, 1);
    put(8'h12); put(8'h34);
    idle(2);
    check("to_idle_error", error, 1);
    check("to_no_write", waddr.size(), base);

    put(8'hA5);
    check("ov_err_clear", error, 0);
    put(8'h80); put(8'h01);
    check("ov_error", error, 1);
    idle(3);
    check("ov_no_write", waddr.size(), base);
    check("ov_hold", cpu_hold, 1);

    put(8'hA5); put(8'h80); put(8'h00);
    idle(1);
    check("max_cnt_ok", error, 0);
    put(8'h12); put(8'h34);
    check("max_wea", wea, 1);
    check("max_addr", addra, 0);
    check("max_data", dina, 16'h1234);
    idle(TO);
    check("max_to_error", error, 1);

    put(8'hA5); put(8'h00); put(8'h03); put(8'hAA); put(8'hBB); put(8'hCC);
    check("rm_addr_pre", addra, 1);
    check("rm_data_pre", dina, 16'hAABB);
    check("rm_hold_pre", cpu_hold, 1);
    reset = 1'b0;
    #1;
    check("rm_wea", wea, 0);
    check("rm_addra", addra, 0);
    check("rm_dina", dina, 0);
    check("rm_hold", cpu_hold, 0);
    check("rm_done", done, 0);
    check("rm_error", error, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(1);

    base = waddr.size();
    put(8'hA5); put(8'h00); put(8'h01); put(8'hBE); put(8'hEF);
`ifdef ROM_LOADER_CHECKSUM_EN
    put(8'hAE);
`else
    idle(1);
`endif
    check("rc_done", done, 1);
    check("rc_hold", cpu_hold, 0);
    idle(2);
    check("rc_writes", waddr.size(), base + 1);
    check("rc_wdata", wdata[base], 16'hBEEF);
    check("rc_error", error, 0);
    check("rc_done_cnt", done_cnt, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
# rom_loader

Writer side of the instruction ROM port. It receives a framed byte stream from the serial receiver and assembles big-endian 16-bit instruction words. Each word is written into the dual-port instruction memory at consecutive addresses through its write port (`wea`/`addra`/`dina`), while the CPU fetches through the read port. The CPU is held in reset for the whole load and is released only when a complete, valid image has been written.

## Interface
- `ADDR_WIDTH`, 15: instruction memory address width; capacity is 2^ADDR_WIDTH words.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle clocks allowed between bytes inside a frame.

- `clock` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte; valid only while `rx_valid` is 1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `wea` out 1: memory write enable; a one-cycle pulse per word.
- `addra` out ADDR_WIDTH: memory write address.
- `dina` out 16: memory write data.
- `cpu_hold` out 1: drives the CPU reset; 1 keeps the CPU in reset.
- `done` out 1: one-cycle pulse when a frame loads successfully.
- `error` out 1: sticky error flag.

## Operation
- Frame format: SYNC, CNT_HI, CNT_LO, then CNT words each sent as HI then LO, then CKSUM. CKSUM is present only with the checksum feature enabled.
- States:
  - IDLE:
    - A byte equal to SYNC_BYTE goes to CNT_HI, clears `error` and sets `cpu_hold`=1.
    - Any other byte is ignored.
  - CNT_HI → CNT_LO: the byte is latched into the count register.
  - CNT_LO, exit depends on the assembled count:
    - count > 2^ADDR_WIDTH: ERR. Nothing has been written.
    - count = 0: CHECK, or DONE when the checksum feature is compiled out.
    - otherwise: DATA_HI.
  - DATA_HI → DATA_LO: the byte is latched as the high byte.
  - DATA_LO: the write is issued.
    - If more words remain: DATA_HI.
    - Else: CHECK, or DONE when the checksum feature is compiled out.
  - CHECK: compare the received byte with the running sum.
    - Equal: DONE.
    - Not equal: ERR.
  - DONE: pulse `done`, clear `cpu_hold`, return to IDLE.
  - ERR: set `error`, keep `cpu_hold`=1, return to IDLE.
- Write address: starts at 0 for each frame and increments by 1 after every write. It never wraps, because count ≤ 2^ADDR_WIDTH is enforced.
- Running sum: 8-bit, modulo 256, over CNT_HI, CNT_LO and every data byte. SYNC and CKSUM are excluded.
- Words are written before the checksum is verified. A failed frame leaves a partial or corrupt image, so `cpu_hold` stays 1 until a later frame succeeds.
- Inter-byte timeout:
  - In any state other than IDLE, a counter increments every clock and clears on `rx_valid`.
  - Reaching TIMEOUT_CYCLES: ERR.
- Timeout and `rx_valid` in the same cycle: the byte wins and the counter clears.

## Timing
- Reset values: `wea`=0, `addra`=0, `dina`=0, `cpu_hold`=0, `done`=0, `error`=0, state IDLE, count/sum/timer all 0.
- `cpu_hold` rises in the cycle after the SYNC strobe.
- Write latency: `wea`=1 with stable `addra`/`dina` in the cycle after the LO byte's `rx_valid`. `addra` advances in the cycle after `wea`.
- `done`:
  - Checksum feature on: pulses in the cycle after the CKSUM strobe.
  - Checksum feature off: pulses in the cycle after the last `wea`.
- `cpu_hold` falls together with the `done` pulse.
- `error` rises in the cycle after the failing byte or the timeout. It holds until the next SYNC is accepted in IDLE.
- Back-to-back `rx_valid` strobes on consecutive cycles are supported. At most one write is issued per two bytes.
- Reset asserted mid-frame: all outputs take their reset values immediately, asynchronously. The partial image in memory is not cleaned up.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined: the CKSUM byte is expected and checked, and a mismatch goes to ERR.
- `ROM_LOADER_CHECKSUM_EN` undefined:
  - No CKSUM byte is expected.
  - The frame ends after the last word.
  - The sum register and the CHECK state are omitted.
  - ERR is reachable only through the count overflow or the timeout.

## Test plan
1. Stream A5 00 02 12 34 AB CD C0 with the macro on → two writes: (0, 16'h1234) then (1, 16'hABCD); `done` pulses once; `error`=0; `cpu_hold` 1→0.
2. Same frame with last byte C1 → both writes still occur; `error`=1; `cpu_hold` stays 1; no `done`. Then send the frame from scenario 1 → `error` clears at SYNC and `done` pulses.
3. Stream 00 FF 7E, then A5 00 00 00 → leading bytes ignored; no `wea`; `done` pulses; `cpu_hold` returns to 0.
4. Stream A5 00 01 12, then no bytes for TIMEOUT_CYCLES clocks → `error`=1, state IDLE, no write issued.
5. With ADDR_WIDTH=15, stream A5 80 01 → `error`=1 after CNT_LO and no `wea` ever. Separately, with count=3, drop `reset` to 0 during the second word → all outputs read their reset values in the same cycle.
6. Macro off, stream A5 00 01 BE EF → write (0, 16'hBEEF); `done` pulses in the cycle after `wea`; the next byte is treated as IDLE input.
